sys_ctrl_tx_serializer: RTL

//  Parametrised TX path of the system controller: accepts register-read data and ALU results,

---
 rtl/sys_ctrl_tx_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : sys_ctrl_tx_serializer
//  Description : TX path of the system controller. It buffers register-read
//                data and ALU results, one entry per source. It slices each
//                result into DATA_WIDTH words and writes them into the TX FIFO,
//                stalling while the FIFO reports Full. Round-robin between
//                sources when both are pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_tx_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int RD_DATA_WIDTH = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int LSB_FIRST     = 1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     Full,
    input  logic [RD_DATA_WIDTH-1:0] Rd_data,
    input  logic                     Rd_data_valid,
    output logic                     Rd_data_ready,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_valid,
    output logic                     ALU_OUT_ready,
    output logic [DATA_WIDTH-1:0]    FIFO_IN,
    output logic                     Wr_Req,
    output logic                     Busy
);

    localparam int N_RD   = RD_DATA_WIDTH / DATA_WIDTH;
    localparam int N_ALU  = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int N_MAX  = (N_RD > N_ALU) ? N_RD : N_ALU;
    localparam int CW     = $clog2(N_MAX) + 1;
    localparam int SW     = N_MAX * DATA_WIDTH;
    // MSB-first frames are left-aligned in the shift register so the first
    // word always sits at the top, whatever the source width.
    localparam int SH_RD  = (LSB_FIRST != 0) ? 0 : (SW - RD_DATA_WIDTH);
    localparam int SH_ALU = (LSB_FIRST != 0) ? 0 : (SW - ALU_OUT_WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic                     rd_pending;
    logic [RD_DATA_WIDTH-1:0] rd_buf;
    logic                     alu_pending;
    logic [ALU_OUT_WIDTH-1:0] alu_buf;
    logic                     rr_alu;       // 0: RD wins next tie, 1: ALU wins
    logic [SW-1:0]            sreg;         // words not yet presented on FIFO_IN
    logic [CW-1:0]            count;
    logic [CW-1:0]            n_words;

    logic                     load;
    logic                     sel_alu;
    logic                     last_word;
    logic [SW-1:0]            load_vec;
    logic [DATA_WIDTH-1:0]    load_first;
    logic [SW-1:0]            load_rest;
    logic [DATA_WIDTH-1:0]    cur_first;
    logic [SW-1:0]            cur_rest;

    assign Rd_data_ready = !rd_pending;
    assign ALU_OUT_ready = !alu_pending;
    assign Wr_Req        = (state == SEND) && !Full;
    assign Busy          = (state != IDLE) || rd_pending || alu_pending;

    // Word extraction order depends on LSB_FIRST
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign load_first = load_vec[DATA_WIDTH-1:0];
            assign load_rest  = load_vec >> DATA_WIDTH;
            assign cur_first  = sreg[DATA_WIDTH-1:0];
            assign cur_rest   = sreg >> DATA_WIDTH;
        end else begin : g_msb
            assign load_first = load_vec[SW-1 -: DATA_WIDTH];
            assign load_rest  = load_vec << DATA_WIDTH;
            assign cur_first  = sreg[SW-1 -: DATA_WIDTH];
            assign cur_rest   = sreg << DATA_WIDTH;
        end
    endgenerate

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, source selection and load vector
    always_comb begin
        state_next = state;
        load       = 1'b0;
        sel_alu    = 1'b0;
        last_word  = (count == (n_words - CW'(1)));
        case (state)
            IDLE: begin
                if (rd_pending || alu_pending) begin
                    load       = 1'b1;
                    sel_alu    = (rd_pending && alu_pending) ? rr_alu : alu_pending;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!Full && last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (sel_alu) begin
            load_vec = SW'(alu_buf) << SH_ALU;
        end else begin
            load_vec = SW'(rd_buf) << SH_RD;
        end
    end

    // Holding buffers, round-robin pointer and word shifter
    always_ff @(posedge CLK) begin
        if (rst) begin
            rd_pending  <= 1'b0;
            rd_buf      <= '0;
            alu_pending <= 1'b0;
            alu_buf     <= '0;
            rr_alu      <= 1'b0;
            sreg        <= '0;
            count       <= '0;
            n_words     <= '0;
            FIFO_IN     <= '0;
        end else begin
            // Ready is !pending, so a capture never coincides with a release
            if (Rd_data_valid && Rd_data_ready) begin
                rd_buf     <= Rd_data;
                rd_pending <= 1'b1;
            end
            if (ALU_OUT_valid && ALU_OUT_ready) begin
                alu_buf     <= ALU_OUT;
                alu_pending <= 1'b1;
            end

            if (load) begin
                sreg    <= load_rest;
                FIFO_IN <= load_first;
                count   <= '0;
                n_words <= sel_alu ? CW'(N_ALU) : CW'(N_RD);
                if (sel_alu) begin
                    alu_pending <= 1'b0;
                end else begin
                    rd_pending <= 1'b0;
                end
                // The pointer only moves on a real contention
                if (rd_pending && alu_pending) begin
                    rr_alu <= !sel_alu;
                end
            end else if (Wr_Req) begin
                if (last_word) begin
                    count <= '0;
                end else begin
                    count   <= count + CW'(1);
                    FIFO_IN <= cur_first;
                    sreg    <= cur_rest;
                end
            end
        end
    end

endmodule
`default_nettype wire
